// File: rtl/score_controller.sv
// Two-player match score keeper: serve delay, point counting, win detection
// and a blinking seven-segment digit for the winner.
module score_controller #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_DELAY  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic       serve_ready,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [1:0] fsm_state
);

    localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DELAY_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

    state_t        state, state_n;
    logic [DW-1:0] delay_cnt, delay_cnt_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink, blink_n;
    logic [3:0]    score1_n, score2_n, hit;
    logic [1:0]    winner_n;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SERVE;
            delay_cnt <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= 2'b00;
        end else begin
            state     <= state_n;
            delay_cnt <= delay_cnt_n;
            blink_cnt <= blink_cnt_n;
            blink     <= blink_n;
            score1    <= score1_n;
            score2    <= score2_n;
            winner    <= winner_n;
        end
    end

    // Score the pulsing player would reach; only used when exactly one pulses.
    assign hit = point_p1 ? score1 + 4'd1 : score2 + 4'd1;

    always_comb begin
        state_n     = state;
        delay_cnt_n = delay_cnt;
        blink_cnt_n = blink_cnt;
        blink_n     = blink;
        score1_n    = score1;
        score2_n    = score2;
        winner_n    = winner;
        if (new_game) begin
            state_n     = SERVE;
            delay_cnt_n = '0;
            blink_cnt_n = '0;
            blink_n     = 1'b0;
            score1_n    = 4'd0;
            score2_n    = 4'd0;
            winner_n    = 2'b00;
        end else begin
            case (state)
                SERVE: begin
                    blink_cnt_n = '0;
                    blink_n     = 1'b0;
                    if (delay_cnt == DELAY_LAST) begin
                        state_n     = PLAY;
                        delay_cnt_n = '0;
                    end else begin
                        delay_cnt_n = delay_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    blink_cnt_n = '0;
                    blink_n     = 1'b0;
                    if (point_p1 != point_p2) begin
                        if (point_p1) score1_n = hit;
                        else          score2_n = hit;
                        if (hit == WIN) begin
                            state_n  = OVER;
                            winner_n = point_p1 ? 2'b01 : 2'b10;
                        end else begin
                            state_n     = SERVE;
                            delay_cnt_n = '0;
                        end
                    end
                end
                OVER: begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_n = '0;
                        blink_n     = ~blink;
                    end else begin
                        blink_cnt_n = blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n     = SERVE;
                    delay_cnt_n = '0;
                    blink_cnt_n = '0;
                    blink_n     = 1'b0;
                end
            endcase
        end
    end

    // The winner's digit goes dark during the blink-on half period.
    always_comb begin
        serve_ready = (state == PLAY);
        game_over   = (state == OVER);
        fsm_state   = state;
        seg1        = decode(score1);
        seg2        = decode(score2);
        if (state == OVER && blink) begin
            if (winner == 2'b01) seg1 = 7'h00;
            if (winner == 2'b10) seg2 = 7'h00;
        end
    end

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller with WIN_SCORE=3, SERVE_DELAY=4, BLINK_CYCLES=3:
// directed scenarios plus a randomized run against a behavioural match model.
module tb_score_controller;

    localparam int WS = 3;
    localparam int SD = 4;
    localparam int BC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] score1, score2;
    logic [6:0] seg1, seg2;
    logic       serve_ready, game_over;
    logic [1:0] winner, fsm_state;

    int vectors = 0;
    int miscompares = 0;

    // Match model: phase 0=waiting to serve, 1=rally, 2=decided.
    int m_phase = 0, m_wait = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_ocyc = 0;

    score_controller #(.WIN_SCORE(WS), .SERVE_DELAY(SD), .BLINK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
        .new_game(new_game), .score1(score1), .score2(score2), .seg1(seg1),
        .seg2(seg2), .serve_ready(serve_ready), .game_over(game_over),
        .winner(winner), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit(input int v);
        case (v)
            0: digit = 7'h3F; 1: digit = 7'h06; 2: digit = 7'h5B; 3: digit = 7'h4F;
            4: digit = 7'h66; 5: digit = 7'h6D; 6: digit = 7'h7D; 7: digit = 7'h07;
            8: digit = 7'h7F; 9: digit = 7'h6F; default: digit = 7'h00;
        endcase
    endfunction

    task automatic model_step(input logic p1, input logic p2, input logic ng, input logic rst);
        if (rst || ng) begin
            m_phase = 0; m_wait = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_ocyc = 0;
        end else if (m_phase == 0) begin
            m_wait++;
            if (m_wait == SD) m_phase = 1;
        end else if (m_phase == 1) begin
            if (p1 && !p2) m_s1++;
            if (p2 && !p1) m_s2++;
            if (p1 != p2) begin
                if (m_s1 == WS || m_s2 == WS) begin
                    m_phase = 2; m_ocyc = 0; m_win = (m_s1 == WS) ? 1 : 2;
                end else begin
                    m_phase = 0; m_wait = 0;
                end
            end
        end else begin
            m_ocyc++;
        end
    endtask

    task automatic tick(input logic p1, input logic p2, input logic ng, input logic rst);
        @(negedge clk);
        point_p1 = p1; point_p2 = p2; new_game = ng; reset = rst;
        @(posedge clk);
        model_step(p1, p2, ng, rst);
        #1;
    endtask

    task automatic wait_play(input string tag);
        int n = 0;
        while (serve_ready !== 1'b1 && n < 10) begin
            tick(0, 0, 0, 0);
            n++;
        end
        vectors++;
        if (serve_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wait_play serve_ready got %b want 1 after %0d cycles", tag, serve_ready, n);
        end
    endtask

    task automatic test_reset;
        tick(0, 0, 0, 1);
        vectors++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs got s1=%0d s2=%0d w=%b go=%b want 0 0 00 0", score1, score2, winner, game_over);
        end
        for (int i = 0; i < SD; i++) begin
            if (i > 0) tick(0, 0, 0, 0);
            vectors++;
            if (serve_ready !== 1'b0 || seg1 !== 7'h3F || seg2 !== 7'h3F) begin
                miscompares++;
                $display("FAIL reset_idle[%0d] got sr=%b seg1=%h seg2=%h want 0 3f 3f", i, serve_ready, seg1, seg2);
            end
        end
        tick(0, 0, 0, 0);
        vectors++;
        if (serve_ready !== 1'b1 || seg1 !== 7'h3F || seg2 !== 7'h3F) begin
            miscompares++;
            $display("FAIL reset_play got sr=%b seg1=%h seg2=%h want 1 3f 3f", serve_ready, seg1, seg2);
        end
    endtask

    task automatic test_point_p1;
        tick(1, 0, 0, 0);
        vectors++;
        if (score1 !== 4'd1 || seg1 !== 7'h06 || score2 !== 4'd0 || seg2 !== 7'h3F) begin
            miscompares++;
            $display("FAIL point_p1 got s1=%0d seg1=%h s2=%0d seg2=%h want 1 06 0 3f", score1, seg1, score2, seg2);
        end
        for (int i = 0; i < SD; i++) begin
            if (i > 0) tick(0, 0, 0, 0);
            vectors++;
            if (serve_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL point_p1_delay[%0d] serve_ready got %b want 0", i, serve_ready);
            end
        end
        tick(0, 0, 0, 0);
        vectors++;
        if (serve_ready !== 1'b1 || score1 !== 4'd1) begin
            miscompares++;
            $display("FAIL point_p1_play got sr=%b s1=%0d want 1 1", serve_ready, score1);
        end
    endtask

    task automatic test_both_and_serve;
        tick(1, 1, 0, 0);
        vectors++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || serve_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL both_points got s1=%0d s2=%0d sr=%b want 1 0 1", score1, score2, serve_ready);
        end
        tick(0, 1, 0, 0);
        vectors++;
        if (score2 !== 4'd1 || seg2 !== 7'h06 || serve_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL p2_in_play got s2=%0d seg2=%h sr=%b want 1 06 0", score2, seg2, serve_ready);
        end
        tick(0, 1, 0, 0);
        vectors++;
        if (score2 !== 4'd1 || score1 !== 4'd1 || serve_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL p2_in_serve got s1=%0d s2=%0d sr=%b want 1 1 0", score1, score2, serve_ready);
        end
        wait_play("both");
    endtask

    task automatic test_p2_wins;
        tick(0, 0, 1, 0);
        wait_play("p2_start");
        for (int k = 0; k < WS; k++) begin
            tick(0, 1, 0, 0);
            if (k < WS - 1) wait_play("p2_rally");
        end
        vectors++;
        if (game_over !== 1'b1 || winner !== 2'b10 || score2 !== 4'd3 || seg2 !== 7'h4F || serve_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL p2_win got go=%b w=%b s2=%0d seg2=%h sr=%b want 1 10 3 4f 0",
                     game_over, winner, score2, seg2, serve_ready);
        end
        for (int j = 1; j <= 4 * BC; j++) begin
            logic [6:0] want2;
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            want2 = ((j / BC) % 2 == 1) ? 7'h00 : 7'h4F;
            vectors++;
            if (seg2 !== want2 || seg1 !== 7'h3F || score1 !== 4'd0 || score2 !== 4'd3 || game_over !== 1'b1) begin
                miscompares++;
                $display("FAIL blink[%0d] got seg2=%h seg1=%h s1=%0d s2=%0d go=%b want %h 3f 0 3 1",
                         j, seg2, seg1, score1, score2, game_over, want2);
            end
        end
    endtask

    task automatic test_new_game;
        tick(1, 0, 1, 0);
        vectors++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL new_game got s1=%0d s2=%0d w=%b go=%b want 0 0 00 0", score1, score2, winner, game_over);
        end
        for (int i = 0; i < SD; i++) begin
            if (i > 0) tick(0, 0, 0, 0);
            vectors++;
            if (serve_ready !== 1'b0 || seg2 !== 7'h3F || seg1 !== 7'h3F) begin
                miscompares++;
                $display("FAIL new_game_delay[%0d] got sr=%b seg1=%h seg2=%h want 0 3f 3f", i, serve_ready, seg1, seg2);
            end
        end
        tick(0, 0, 0, 0);
        vectors++;
        if (serve_ready !== 1'b1 || seg2 !== 7'h3F) begin
            miscompares++;
            $display("FAIL new_game_play got sr=%b seg2=%h want 1 3f", serve_ready, seg2);
        end
    endtask

    task automatic test_reset_mid_delay;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 1);
        vectors++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00 || game_over !== 1'b0 ||
            seg1 !== 7'h3F || seg2 !== 7'h3F) begin
            miscompares++;
            $display("FAIL reset_mid got s1=%0d s2=%0d w=%b go=%b seg1=%h seg2=%h want 0 0 00 0 3f 3f",
                     score1, score2, winner, game_over, seg1, seg2);
        end
        for (int i = 0; i < SD; i++) begin
            if (i > 0) tick(0, 0, 0, 0);
            vectors++;
            if (serve_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_delay[%0d] serve_ready got %b want 0", i, serve_ready);
            end
        end
        tick(0, 0, 0, 0);
        vectors++;
        if (serve_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_play serve_ready got %b want 1", serve_ready);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 800; n++) begin
            int r;
            logic [25:0] got, want;
            logic blank;
            r = $urandom_range(0, 199);
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, r >= 2 && r < 6, r < 2);
            blank = (m_phase == 2) && ((m_ocyc / BC) % 2 == 1);
            want = {4'(m_s1), 4'(m_s2),
                    (blank && m_win == 1) ? 7'h00 : digit(m_s1),
                    (blank && m_win == 2) ? 7'h00 : digit(m_s2),
                    m_phase == 1, m_phase == 2, 2'(m_win)};
            got = {score1, score2, seg1, seg2, serve_ready, game_over, winner};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random[%0d] {s1,s2,seg1,seg2,sr,go,w} got %h want %h", n, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_point_p1();
        test_both_and_serve();
        test_p2_wins();
        test_new_game();
        test_reset_mid_delay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
